// File: rtl/mode_reg_n.sv
// mode_reg_n: multi-mode datapath register (load/shift/rotate/count) with carry-out chaining.
// Define MODE_REG_UNDO_EN to add a one-level Undo port backed by a shadow register.
module mode_reg_n #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             Sin,
`ifdef MODE_REG_UNDO_EN
    input  logic             Undo,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Cout,
    output logic             Zero
);
    localparam logic [WIDTH-1:0] RV = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_nx;
    logic             c_nx;

    always_comb begin
        q_nx = Q;
        c_nx = Cout;
        case (Mode)
            3'd1: {c_nx, q_nx} = {1'b0, D};
            3'd2: {c_nx, q_nx} = {Q, Sin};
            3'd3: {q_nx, c_nx} = {Sin, Q};
            3'd4: {c_nx, q_nx} = {Q[WIDTH-1], Q[WIDTH-2:0], Q[WIDTH-1]};
            3'd5: {q_nx, c_nx} = {Q[0], Q[WIDTH-1:1], Q[0]};
            3'd6: {c_nx, q_nx} = {1'b0, Q} + (WIDTH+1)'(1);
            3'd7: {c_nx, q_nx} = {Q == '0, Q - WIDTH'(1)};
            default: ;
        endcase
    end

`ifdef MODE_REG_UNDO_EN
    logic [WIDTH-1:0] sh;

    // Shadow captures the pre-update value of every real operation, so Undo steps back one.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            Q    <= RV;
            Cout <= 1'b0;
            sh   <= RV;
        end else if (Undo) begin
            Q    <= sh;
            Cout <= 1'b0;
        end else if (En) begin
            Q    <= q_nx;
            Cout <= c_nx;
            if (Mode != 3'd0)
                sh <= Q;
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (Clr) begin
            Q    <= RV;
            Cout <= 1'b0;
        end else if (En) begin
            Q    <= q_nx;
            Cout <= c_nx;
        end
    end
`endif

    assign Qn   = ~Q;
    assign Zero = (Q == '0);
endmodule
